// File: rtl/as_watchdog.sv
// AS heartbeat watchdog: arms on a heartbeat edge train, trips on timeout.
// Optional minimum-interval check with `define AS_WDG_WINDOW_EN.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   Heartbeat    async toggle from the AS computer (both edges count)
//   Fault_clear  single-cycle request to leave TRIPPED
//   Watchdog     1 = AS healthy (registered, glitch-free)
//   Wdg_state    00 IDLE, 01 ARMING, 10 OK, 11 TRIPPED
//   Fault_code   00 none, 01 timeout, 10 too-fast edge
module as_watchdog #(
    parameter int TIMEOUT_CYCLES    = 1000,
    parameter int ARM_EDGES         = 4,
    parameter int MIN_PERIOD_CYCLES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Heartbeat,
    input  logic       Fault_clear,
    output logic       Watchdog,
    output logic [1:0] Wdg_state,
    output logic [1:0] Fault_code
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CW = $clog2(ARM_EDGES + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_ARM  = 2'b01,
        S_OK   = 2'b10,
        S_TRIP = 2'b11
    } state_t;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_TIMEOUT = 2'b01;
    localparam logic [1:0] FC_FAST    = 2'b10;

    state_t          r_state;
    logic            r_sync1;
    logic            r_sync2;
    logic            r_sync3;
    logic [TW-1:0]   r_timer;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_fault;
    logic            r_wdg;

    state_t          w_nstate;
    logic [1:0]      w_nfault;
    logic [CW-1:0]   w_ncnt;
    logic [CW-1:0]   w_cnt_inc;
    logic            w_edge;
    logic            w_timeout;
    logic            w_too_fast;
    logic            w_clear;

    assign w_edge    = r_sync2 ^ r_sync3;
    assign w_timeout = (r_timer == TW'(TIMEOUT_CYCLES - 1));
    assign w_cnt_inc = r_cnt + CW'(1);
    assign w_clear   = (r_state == S_TRIP) && Fault_clear;

`ifdef AS_WDG_WINDOW_EN
    assign w_too_fast = w_edge &&
                        (r_timer < TW'(MIN_PERIOD_CYCLES - 1));
`else
    assign w_too_fast = 1'b0;
`endif

    // Next-state logic; an edge outranks a same-cycle timeout.
    always_comb begin
        w_nstate = r_state;
        w_nfault = r_fault;
        w_ncnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_ncnt   = CW'(1);
                    w_nstate = (ARM_EDGES == 1) ? S_OK : S_ARM;
                end
            end
            S_ARM, S_OK: begin
                if (w_too_fast) begin
                    w_nstate = S_TRIP;
                    w_nfault = FC_FAST;
                end else if (w_edge) begin
                    if (r_state == S_ARM) begin
                        w_ncnt = w_cnt_inc;
                        if (w_cnt_inc >= CW'(ARM_EDGES)) begin
                            w_nstate = S_OK;
                        end
                    end
                end else if (w_timeout) begin
                    w_nstate = S_TRIP;
                    w_nfault = FC_TIMEOUT;
                end
            end
            S_TRIP: begin
                if (Fault_clear) begin
                    w_nstate = S_IDLE;
                    w_nfault = FC_NONE;
                    w_ncnt   = '0;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
            r_state <= S_IDLE;
            r_fault <= FC_NONE;
            r_cnt   <= '0;
            r_timer <= '0;
            r_wdg   <= 1'b0;
        end else begin
            r_sync1 <= Heartbeat;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
            r_state <= w_nstate;
            r_fault <= w_nfault;
            r_cnt   <= w_ncnt;
            // Watchdog tracks the state register entering/leaving OK.
            r_wdg   <= (w_nstate == S_OK);
            if (w_clear || w_edge) begin
                r_timer <= '0;
            end else if (r_timer != TW'(TIMEOUT_CYCLES)) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    assign Watchdog   = r_wdg;
    assign Wdg_state  = r_state;
    assign Fault_code = r_fault;

endmodule

// File: tb/tb_as_watchdog.sv
// Self-checking bench for as_watchdog (TIMEOUT=20, ARM_EDGES=3, MIN=4).
// Vector table drives stimulus; expectations flow through a queue.
module tb_as_watchdog;

    localparam logic [1:0] ID = 2'd0;
    localparam logic [1:0] AR = 2'd1;
    localparam logic [1:0] OK = 2'd2;
    localparam logic [1:0] TR = 2'd3;

`ifdef AS_WDG_WINDOW_EN
    localparam bit WIN = 1'b1;
`else
    localparam bit WIN = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic       fclr;
        logic       tog;
        int         n;
        logic [1:0] st;
        logic       wd;
        logic [1:0] fc;
    } vec_t;

    typedef struct {
        int         row;
        logic [1:0] st;
        logic       wd;
        logic [1:0] fc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Heartbeat = 1'b0;
    logic       Fault_clear = 1'b0;
    logic       Watchdog;
    logic [1:0] Wdg_state;
    logic [1:0] Fault_code;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    as_watchdog #(
        .TIMEOUT_CYCLES   (20),
        .ARM_EDGES        (3),
        .MIN_PERIOD_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Heartbeat  (Heartbeat),
        .Fault_clear(Fault_clear),
        .Watchdog   (Watchdog),
        .Wdg_state  (Wdg_state),
        .Fault_code (Fault_code)
    );

    always #5 clk = ~clk;

    function automatic void add(logic rst, logic fclr, logic tog, int n,
                                logic [1:0] st, logic wd, logic [1:0] fc);
        vec_t v;
        v.rst = rst; v.fclr = fclr; v.tog = tog; v.n = n;
        v.st = st; v.wd = wd; v.fc = fc;
        vecs.push_back(v);
    endfunction

    // Three toggles 10 cycles apart; checks the 3-edge latency of each.
    function automatic void arm_seq();
        add(0, 0, 1, 2, ID, 0, 0);
        add(0, 0, 0, 1, AR, 0, 0);
        add(0, 0, 0, 7, AR, 0, 0);
        add(0, 0, 1, 2, AR, 0, 0);
        add(0, 0, 0, 1, AR, 0, 0);
        add(0, 0, 0, 7, AR, 0, 0);
        add(0, 0, 1, 2, AR, 0, 0);
        add(0, 0, 0, 1, OK, 1, 0);
    endfunction

    task automatic apply(input int idx, input vec_t v);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset = v.rst;
        Fault_clear = v.fclr;
        if (v.rst) Heartbeat = 1'b0;
        else if (v.tog) Heartbeat = ~Heartbeat;
        e.row = idx; e.st = v.st; e.wd = v.wd; e.fc = v.fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        Fault_clear = 1'b0;
        repeat (v.n - 1) @(posedge clk);
        #1;
        g = exp_q.pop_front();
        checks++;
        if (Wdg_state !== g.st || Watchdog !== g.wd ||
            Fault_code !== g.fc) begin
            failures++;
            $display("FAIL row%0d got st=%0d wd=%0d fc=%0d want st=%0d wd=%0d fc=%0d",
                     g.row, Wdg_state, Watchdog, Fault_code,
                     g.st, g.wd, g.fc);
        end
    endtask

    initial begin
        // Reset held two cycles, then idle after release.
        add(1, 0, 0, 1, ID, 0, 0);
        add(1, 0, 0, 1, ID, 0, 0);
        add(0, 0, 0, 3, ID, 0, 0);
        add(0, 1, 0, 1, ID, 0, 0);
        arm_seq();
        // Fault_clear ignored in OK, then timeout 20 after last edge.
        add(0, 1, 0, 1, OK, 1, 0);
        add(0, 0, 0, 18, OK, 1, 0);
        add(0, 0, 0, 1, TR, 0, 1);
        // Edges ignored while tripped.
        add(0, 0, 1, 3, TR, 0, 1);
        add(0, 0, 0, 5, TR, 0, 1);
        add(0, 1, 0, 1, ID, 0, 0);
        // Full arming sequence needed again.
        arm_seq();
        // Two edges 2 cycles apart in OK.
        add(0, 0, 0, 7, OK, 1, 0);
        add(0, 0, 1, 2, OK, 1, 0);
        add(0, 0, 1, 2, OK, 1, 0);
        add(0, 0, 0, 1, WIN ? TR : OK, WIN ? 1'b0 : 1'b1,
            WIN ? 2'd2 : 2'd0);
        // Reset dominates a same-cycle Fault_clear.
        add(1, 1, 0, 1, ID, 0, 0);
        // Reset mid-ARMING after the 2nd edge.
        add(0, 0, 1, 2, ID, 0, 0);
        add(0, 0, 0, 1, AR, 0, 0);
        add(0, 0, 0, 7, AR, 0, 0);
        add(0, 0, 1, 2, AR, 0, 0);
        add(0, 0, 0, 1, AR, 0, 0);
        add(0, 0, 0, 2, AR, 0, 0);
        add(1, 0, 0, 1, ID, 0, 0);
        add(0, 0, 0, 4, ID, 0, 0);
        arm_seq();
        // Edge coinciding with the timeout boundary keeps OK.
        add(0, 0, 0, 17, OK, 1, 0);
        add(0, 0, 1, 2, OK, 1, 0);
        add(0, 0, 0, 1, OK, 1, 0);
        add(0, 0, 0, 1, OK, 1, 0);
        // Timeout while ARMING.
        add(1, 0, 0, 1, ID, 0, 0);
        add(0, 0, 1, 2, ID, 0, 0);
        add(0, 0, 0, 1, AR, 0, 0);
        add(0, 0, 0, 18, AR, 0, 0);
        add(0, 0, 0, 1, AR, 0, 0);
        add(0, 0, 0, 1, TR, 0, 1);
        add(0, 0, 0, 1, TR, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(i, vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/as_watchdog.md
AS_WATCHDOG -- requirements
Module: as_watchdog

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 1000: maximum cycles allowed between detected heartbeat edges.
REQ-002 Parameter ARM_EDGES, 4: detected edges required, including the first, before Watchdog asserts; legal range >= 1.
REQ-003 Parameter MIN_PERIOD_CYCLES, 10: minimum cycles between edges when the window check is compiled in; must be < TIMEOUT_CYCLES.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 Heartbeat  in  1  toggle from the AS computer, asynchronous to clk; both edges count.
REQ-007 Fault_clear  in  1  single-cycle request to leave TRIPPED.
REQ-008 Watchdog  out  1  1 = AS healthy; drives the SDC controller's Watchdog input.
REQ-009 Wdg_state  out  2  state encoding: 00 IDLE, 01 ARMING, 10 OK, 11 TRIPPED.
REQ-010 Fault_code  out  2  latched cause: 00 none, 01 timeout, 10 too-fast edge, 11 reserved (never driven).

Function
REQ-011 Heartbeat SHALL pass through a 2-flop synchronizer plus a third history flop; an edge is detected when stage 2 differs from stage 3.
REQ-012 Detection latency SHALL be exactly 3 cycles from the first clk edge sampling a new Heartbeat level to the resulting state/output change.
REQ-013 Interval timer, width $clog2(TIMEOUT_CYCLES+1), SHALL clear on a detected edge, otherwise increment, saturating at TIMEOUT_CYCLES.
REQ-014 IDLE: Watchdog=0; no timeout applied; a detected edge -> ARMING with edge counter = 1 (ARM_EDGES=1 -> directly to OK).
REQ-015 ARMING: each valid detected edge increments the edge counter; when it reaches ARM_EDGES -> OK.
REQ-016 OK: Watchdog=1; remains while valid edges keep arriving.
REQ-017 Timeout: in ARMING or OK, timer == TIMEOUT_CYCLES-1 with no edge this cycle -> TRIPPED, Fault_code=01.
REQ-018 Simultaneous edge and timeout condition SHALL resolve as a valid edge (no trip).
REQ-019 TRIPPED: Watchdog=0; state and Fault_code latched; edges ignored.
REQ-020 Fault_clear in TRIPPED -> IDLE, Fault_code=00, timer and edge counter cleared; Fault_clear in any other state is ignored.
REQ-021 Watchdog SHALL be a dedicated flop loaded from (next_state==OK), so it changes in the same cycle Wdg_state enters or leaves OK, glitch-free.
REQ-022 Re-entry after a trip SHALL require the full ARM_EDGES sequence again.

Reset
REQ-023 reset SHALL dominate all inputs, including Fault_clear and a same-cycle edge.
REQ-024 On reset: Wdg_state=00, Watchdog=0, Fault_code=00, timer=0, edge counter=0, synchronizer flops=0.
REQ-025 reset asserted in any state, including mid-ARMING or TRIPPED, SHALL return to IDLE on the next clk edge.

Configuration
REQ-026 Macro AS_WDG_WINDOW_EN.
- Defined: in ARMING or OK, a detected edge with timer < MIN_PERIOD_CYCLES-1 -> TRIPPED, Fault_code=10.
- Undefined: no minimum-interval check; Fault_code=10 is never produced and MIN_PERIOD_CYCLES is unused.

Verification (TIMEOUT_CYCLES=20, ARM_EDGES=3, MIN_PERIOD_CYCLES=4)
REQ-027 Reset held 2 cycles -> Wdg_state=00, Watchdog=0, Fault_code=00 throughout and after release.
REQ-028 Heartbeat toggled every 10 cycles -> ARMING 3 cycles after the 1st toggle; OK and Watchdog=1 3 cycles after the 3rd toggle.
REQ-029 In OK, toggling stops -> Watchdog=0, Wdg_state=11, Fault_code=01 exactly 20 cycles after the last detected edge.
REQ-030 In OK, two toggles 2 cycles apart -> with macro: TRIPPED, Fault_code=10 at the 2nd detection; without macro: stays OK.
REQ-031 TRIPPED plus 1-cycle Fault_clear -> IDLE, Fault_code=00; Fault_clear pulsed in OK -> no change.
REQ-032 reset pulsed after the 2nd edge in ARMING -> IDLE; three further 10-cycle toggles are required to reach OK.
